// File: rtl/cache_def.sv
// cache_def: request/response types and address field constants shared by the cache and its memory.
package cache_def;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;
endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port line storage, synchronous write, combinational read, power-up pattern = word address.
module cache_mem_array
  import cache_def::*;
#(
  parameter int LINES = 1024,
  localparam int IW = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  typedef logic [LINE_W-1:0] store_t [LINES];
  function automatic store_t init_store();
    store_t s;
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < 4; w++)
        s[l][32*w+:32] = 32'(l * 4 + w);
    return s;
  endfunction
  store_t store = init_store();
  always_ff @(posedge clk)
    if (we) store[idx] <= wdata;
  assign rdata = store[idx];
endmodule

// File: rtl/cache_mem_resp.sv
// cache_mem_resp: fixed-latency memory model answering one cache request at a time.
module cache_mem_resp
  import cache_def::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy,
  output logic         err
);
  localparam int IW     = $clog2(LINES);
  localparam int CW     = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int LOAD   = LATENCY > 1 ? LATENCY - 2 : 0;
  localparam bit DIRECT = LATENCY == 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              rw_q;
  logic [IW-1:0]     idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata;
  logic [IW-1:0]     req_idx;
  logic              accept;
  logic              enter_resp;
  logic              cur_rw;
  logic [IW-1:0]     cur_idx;
  logic [LINE_W-1:0] cur_wdata;
  logic              unused_addr;
  assign req_idx     = mem_req.addr[OFFSET_W+:IW];
  assign unused_addr = ^{mem_req.addr[ADDR_W-1:OFFSET_W+IW], mem_req.addr[OFFSET_W-1:0]};
  assign accept      = state != BUSY && mem_req.valid;
  assign enter_resp  = DIRECT ? accept : state == BUSY && cnt == '0;
  // With single-cycle latency the request is served straight from the inputs.
  assign cur_rw      = DIRECT ? mem_req.rw : rw_q;
  assign cur_idx     = DIRECT ? req_idx : idx_q;
  assign cur_wdata   = DIRECT ? mem_req.data : wdata_q;
  cache_mem_array #(.LINES(LINES)) u_array (
    .clk  (clk),
    .we   (enter_resp && cur_rw),
    .idx  (cur_idx),
    .wdata(cur_wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rw_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_data.ready <= enter_resp;
      if (enter_resp) mem_data.data <= cur_rw ? cur_wdata : rdata;
      busy <= accept || state == BUSY;
      err  <= err || (state == BUSY && mem_req.valid);
      if (accept) begin
        rw_q    <= mem_req.rw;
        idx_q   <= req_idx;
        wdata_q <= mem_req.data;
        cnt     <= CW'(LOAD);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      state <= enter_resp ? RESP : accept ? BUSY : state == BUSY ? BUSY : IDLE;
    end
  end
endmodule

// File: tb/tb_cache_mem_resp.sv
// tb_cache_mem_resp: directed checks of latency, read/write data, back-to-back, drop and reset behaviour.
module tb_cache_mem_resp;
  import cache_def::*;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  mem_req_type  mem_req = '0;
  mem_data_type mem_data;
  logic         busy;
  logic         err;
  int           checks = 0;
  int           errors = 0;
  localparam logic [127:0] W1 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] W2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W3 = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;
  cache_mem_resp #(.LATENCY(4), .LINES(1024)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .mem_data(mem_data),
    .busy    (busy),
    .err     (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pat(input int line);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[32*w+:32] = 32'(line * 4 + w);
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] addr, input logic [127:0] data, input logic rw);
    mem_req = '{addr: addr, data: data, rw: rw, valid: 1'b1};
  endtask
  task automatic idle_req();
    mem_req.valid = 1'b0;
  endtask
  initial begin
    int pulses;
    #2;
    chk("rst_ready", 128'(mem_data.ready), 128'd0);
    chk("rst_data", mem_data.data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    step();
    step();
    rst = 1'b1;
    step();
    // Read of line 0x10: ready only in k+4, busy k+1..k+4.
    drive(32'h100, '0, 1'b0);
    step();
    idle_req();
    chk("rd_k1_busy", 128'(busy), 128'd1);
    chk("rd_k1_ready", 128'(mem_data.ready), 128'd0);
    step();
    chk("rd_k2_ready", 128'(mem_data.ready), 128'd0);
    step();
    chk("rd_k3_ready", 128'(mem_data.ready), 128'd0);
    chk("rd_k3_busy", 128'(busy), 128'd1);
    step();
    chk("rd_k4_ready", 128'(mem_data.ready), 128'd1);
    chk("rd_k4_busy", 128'(busy), 128'd1);
    chk("rd_k4_data", mem_data.data, 128'h00000043_00000042_00000041_00000040);
    step();
    chk("rd_k5_ready", 128'(mem_data.ready), 128'd0);
    chk("rd_k5_busy", 128'(busy), 128'd0);
    chk("rd_k5_hold", mem_data.data, 128'h00000043_00000042_00000041_00000040);
    // Write then aliased read of the same line.
    drive(32'h200, W1, 1'b1);
    step();
    idle_req();
    step();
    step();
    step();
    chk("wr_ready", 128'(mem_data.ready), 128'd1);
    chk("wr_echo", mem_data.data, W1);
    step();
    drive(32'h208, '0, 1'b0);
    step();
    idle_req();
    step();
    step();
    step();
    chk("rbw_ready", 128'(mem_data.ready), 128'd1);
    chk("rbw_data", mem_data.data, W1);
    step();
    // Back-to-back: read issued during the write's ready cycle.
    drive(32'h300, W2, 1'b1);
    step();
    idle_req();
    step();
    step();
    step();
    chk("b2b_wr_ready", 128'(mem_data.ready), 128'd1);
    chk("b2b_wr_data", mem_data.data, W2);
    drive(32'h400, '0, 1'b0);
    step();
    idle_req();
    chk("b2b_k1_ready", 128'(mem_data.ready), 128'd0);
    chk("b2b_k1_busy", 128'(busy), 128'd1);
    step();
    chk("b2b_k2_ready", 128'(mem_data.ready), 128'd0);
    step();
    chk("b2b_k3_ready", 128'(mem_data.ready), 128'd0);
    step();
    chk("b2b_k4_ready", 128'(mem_data.ready), 128'd1);
    chk("b2b_k4_data", mem_data.data, 128'h00000103_00000102_00000101_00000100);
    chk("b2b_err", 128'(err), 128'd0);
    step();
    chk("b2b_done_busy", 128'(busy), 128'd0);
    // Request while busy is dropped and sets sticky err.
    drive(32'h100, '0, 1'b0);
    step();
    idle_req();
    step();
    drive(32'h500, W3, 1'b1);
    step();
    idle_req();
    chk("drop_err", 128'(err), 128'd1);
    step();
    chk("drop_ready", 128'(mem_data.ready), 128'd1);
    chk("drop_data", mem_data.data, 128'h00000043_00000042_00000041_00000040);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses += int'(mem_data.ready);
    end
    chk("drop_no_2nd", 128'(pulses), 128'd0);
    chk("drop_err_sticky", 128'(err), 128'd1);
    chk("drop_idle_busy", 128'(busy), 128'd0);
    // Write abandoned by reset two cycles after acceptance.
    drive(32'h600, W3, 1'b1);
    step();
    idle_req();
    step();
    rst = 1'b0;
    #1;
    chk("arst_ready", 128'(mem_data.ready), 128'd0);
    chk("arst_data", mem_data.data, 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_err", 128'(err), 128'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(mem_data.ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(mem_data.ready);
    end
    chk("arst_no_ready", 128'(pulses), 128'd0);
    drive(32'h600, '0, 1'b0);
    step();
    idle_req();
    step();
    step();
    step();
    chk("arst_rd_ready", 128'(mem_data.ready), 128'd1);
    chk("arst_rd_data", mem_data.data, pat(32'h60));
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_mem_resp.md
CACHE_MEM_RESP -- requirements
Module: cache_mem_resp

Interface
REQ-001 Parameter LATENCY, default 4, means cycles from request acceptance to the ready pulse (legal range 1..15).
REQ-002 Parameter LINES, default 1024, means number of 128-bit lines held in backing storage (power of two).
REQ-003 clk  input  1  means the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  means the reset: asynchronous, active-low.
REQ-005 mem_req  input  mem_req_type  means the request from the cache controller (addr[31:0], data[127:0], rw, valid).
REQ-006 mem_data  output  mem_data_type  means the response to the cache controller (data[127:0], ready).
REQ-007 busy  output  1  means a request is accepted and its response is not yet delivered.
REQ-008 err  output  1  means the sticky flag for a request dropped while busy.

Function
REQ-009 Requests are single-cycle pulses; the block SHALL sample mem_req.valid, addr, data and rw only in the acceptance cycle and SHALL NOT require valid to be held.
REQ-010 Line index SHALL be addr[4+$clog2(LINES)-1:4]; addr[3:0] and the bits above the index SHALL be ignored (aliasing permitted).
REQ-011 FSM states SHALL be IDLE, BUSY and RESP.
REQ-012 IDLE: valid=1 SHALL capture the request and go to BUSY; with LATENCY==1 it SHALL go directly to RESP.
REQ-013 BUSY: a down-counter of width $clog2(LATENCY) SHALL run, and the FSM SHALL enter RESP so that mem_data.ready is high exactly LATENCY cycles after the acceptance cycle.
REQ-014 RESP: mem_data.ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unless a new request is accepted.
REQ-015 A request with valid=1 during RESP SHALL be accepted (back-to-back), and its ready SHALL follow LATENCY cycles after that RESP cycle; this supports the write_back-to-allocate handoff.
REQ-016 Write (rw=1): the captured data SHALL be committed to the indexed line at the edge entering RESP, and mem_data.data in RESP SHALL echo the written line.
REQ-017 Read (rw=0): mem_data.data in RESP SHALL be the indexed line as stored at the edge entering RESP, so it includes any earlier completed write.
REQ-018 mem_data.data SHALL be registered and SHALL hold its last response value whenever ready=0.
REQ-019 busy SHALL be 1 in BUSY and RESP and 0 in IDLE.
REQ-020 valid=1 in BUSY SHALL be ignored: no capture and no effect on the outstanding response; err SHALL set and stay set until reset.
REQ-021 Only one request SHALL be outstanding at a time; there is no queueing.

Reset
REQ-022 While rst=0, the FSM SHALL be in IDLE, the counter 0, mem_data.ready=0, mem_data.data=0, busy=0 and err=0, regardless of clk.
REQ-023 Reset mid-operation SHALL abandon the outstanding request without a ready pulse; a write not yet committed SHALL be lost.
REQ-024 Backing storage SHALL NOT be reset; at simulation start, word w of line L SHALL hold 32-bit value L*4+w (the word address).

Structure
REQ-025 mem_req_type, mem_data_type and the address field constants SHALL come from the shared cache_def package; no new types SHALL be added to it.
REQ-026 The FSM state enum SHALL be local to the module.
REQ-027 Storage SHALL be a sub-module cache_mem_array (one read/write port, synchronous write, index in, 128-bit line out).

Verification (LATENCY=4, LINES=1024)
REQ-028 Assert rst=0 mid-run -> ready=0, data=0, busy=0 and err=0 immediately, without waiting for a clock edge.
REQ-029 Read pulse addr=0x00000100 at cycle k -> ready=1 only in cycle k+4, data=0x00000043_00000042_00000041_00000040, busy=1 in k+1..k+4.
REQ-030 Write addr=0x00000200 data=0xDEADBEEF_CAFEF00D_12345678_9ABCDEF0, then read addr=0x00000208 -> read returns the same 128-bit value.
REQ-031 Write pulse to 0x00000300, then a read of 0x00000400 issued in the write's ready cycle -> read accepted, second ready exactly 4 cycles later, data=0x00000103_00000102_00000101_00000100, err=0.
REQ-032 Read 0x00000100, then valid pulse for 0x00000500 two cycles later -> err=1 sticky, first response unaffected, no second ready.
REQ-033 Write accepted, rst=0 asserted two cycles later -> no ready pulse; after release, a read of that line returns the initial pattern.
